// File: rtl/led_panel_receiver_pkg.sv
// Shared constants, state type and sizing helper for the HUB75 row receiver.
package led_panel_receiver_pkg;

  localparam int COLS = 64;
  localparam int ROWS = 64;

  function automatic int bits_for(input int n);
    int b;
    b = 1;
    for (int i = 1; i < 31; i++)
      if (n >= (1 << i)) b = i + 1;
    return b;
  endfunction

  localparam int ADDR_BITS = bits_for(ROWS / 2 - 1);
  localparam int CNT_BITS  = bits_for(COLS);

  // Bit positions of each colour within an LP_RGB pin group.
  localparam int RGB_R = 0;
  localparam int RGB_G = 1;
  localparam int RGB_B = 2;

  typedef enum logic {
    ST_SHIFT,
    ST_LATCHED
  } state_t;

endpackage

// File: rtl/led_panel_receiver_if.sv
// Panel pin side and row-write side of the receiver, bundled for port connection.
interface led_panel_receiver_if;
  import led_panel_receiver_pkg::*;

  logic                  lp_clock;
  logic                  lp_latch;
  logic                  lp_blank;
  logic [2:0]            lp_rgb_0;
  logic [2:0]            lp_rgb_1;
  logic [ADDR_BITS-1:0]  lp_address;
  logic                  row_valid;
  logic                  row_ready;
  logic [ADDR_BITS-1:0]  row_address;
  logic [3*COLS-1:0]     row_data_0;
  logic [3*COLS-1:0]     row_data_1;
  logic                  length_error;
  logic                  overrun;

  modport master (
    output lp_clock, lp_latch, lp_blank, lp_rgb_0, lp_rgb_1, lp_address, row_ready,
    input  row_valid, row_address, row_data_0, row_data_1, length_error, overrun
  );

  modport slave (
    input  lp_clock, lp_latch, lp_blank, lp_rgb_0, lp_rgb_1, lp_address, row_ready,
    output row_valid, row_address, row_data_0, row_data_1, length_error, overrun
  );

endinterface

// File: rtl/led_panel_receiver_input_sync.sv
// Two-flop synchroniser with registered rise/fall flags; q is aligned with the flags.
module led_panel_receiver_input_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

  assign q = s3;

endmodule

// File: rtl/led_panel_receiver.sv
// HUB75 sniffer: deserialises shifted row pairs and presents them as frame-buffer row writes.
//   state      | meaning
//   ST_SHIFT   | collecting pixels, no row waiting in the shadow registers
//   ST_LATCHED | shadow holds a latched row, waiting for blank to fall
module led_panel_receiver (
  input logic            i_clock,
  input logic            i_reset_n,
  led_panel_receiver_if.slave bus
);
  import led_panel_receiver_pkg::*;

  localparam int SW = 9 + ADDR_BITS;
  localparam int DW = 3 * COLS;

  logic [SW-1:0] sync_q, sync_rise, sync_fall;

  led_panel_receiver_input_sync #(.W(SW)) u_sync (
    .clk   (i_clock),
    .rst_n (i_reset_n),
    .d     ({bus.lp_address, bus.lp_rgb_1, bus.lp_rgb_0, bus.lp_blank, bus.lp_latch, bus.lp_clock}),
    .q     (sync_q),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  logic                 clk_rise, latch_rise, blank_fall;
  logic [2:0]           rgb_0, rgb_1;
  logic [ADDR_BITS-1:0] addr_s;
  logic                 unused_sync;

  assign clk_rise    = sync_rise[0];
  assign latch_rise  = sync_rise[1];
  assign blank_fall  = sync_fall[2];
  assign rgb_0       = sync_q[5:3];
  assign rgb_1       = sync_q[8:6];
  assign addr_s      = sync_q[SW-1:9];
  assign unused_sync = ^{sync_q[2:0], sync_rise[SW-1:2], sync_fall[SW-1:3], sync_fall[1:0]};

  state_t               state, state_next;
  logic [DW-1:0]        shift_0, shift_1, shadow_0, shadow_1;
  logic [CNT_BITS-1:0]  count;
  logic                 take_shadow, clear_count, len_err_next, ovr_latch, xfer;
  logic [DW-1:0]        xfer_0, xfer_1;
  logic                 row_valid, length_error, overrun;
  logic [ADDR_BITS-1:0] row_address;
  logic [DW-1:0]        row_data_0, row_data_1;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) state <= ST_SHIFT;
    else            state <= state_next;
  end

  // Latch is resolved before blank so a coincident pair commits the freshly latched row.
  always_comb begin
    state_next   = state;
    take_shadow  = 1'b0;
    clear_count  = 1'b0;
    len_err_next = 1'b0;
    ovr_latch    = 1'b0;
    xfer         = 1'b0;
    case (state)
      ST_SHIFT: if (latch_rise) begin
        take_shadow  = 1'b1;
        clear_count  = 1'b1;
        len_err_next = (count != CNT_BITS'(COLS));
        state_next   = ST_LATCHED;
      end
      ST_LATCHED: if (latch_rise) begin
        take_shadow = 1'b1;
        clear_count = 1'b1;
        ovr_latch   = 1'b1;
      end
    endcase
    if (state_next == ST_LATCHED && blank_fall) begin
      xfer       = 1'b1;
      state_next = ST_SHIFT;
    end
  end

  assign xfer_0 = take_shadow ? shift_0 : shadow_0;
  assign xfer_1 = take_shadow ? shift_1 : shadow_1;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      shift_0      <= '0;
      shift_1      <= '0;
      shadow_0     <= '0;
      shadow_1     <= '0;
      count        <= '0;
      row_valid    <= 1'b0;
      row_address  <= '0;
      row_data_0   <= '0;
      row_data_1   <= '0;
      length_error <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      length_error <= len_err_next;
      overrun      <= ovr_latch;
      if (clk_rise) begin
        shift_0 <= {shift_0[DW-4:0], rgb_0[RGB_R], rgb_0[RGB_G], rgb_0[RGB_B]};
        shift_1 <= {shift_1[DW-4:0], rgb_1[RGB_R], rgb_1[RGB_G], rgb_1[RGB_B]};
      end
      if (clear_count)
        count <= '0;
      else if (clk_rise && count != CNT_BITS'(COLS))
        count <= count + CNT_BITS'(1);
      if (take_shadow) begin
        shadow_0 <= shift_0;
        shadow_1 <= shift_1;
      end
      if (xfer && (!row_valid || bus.row_ready)) begin
        row_data_0  <= xfer_0;
        row_data_1  <= xfer_1;
        row_address <= addr_s;
        row_valid   <= 1'b1;
      end else begin
        if (xfer) overrun <= 1'b1;
        if (bus.row_ready) row_valid <= 1'b0;
      end
    end
  end

  assign bus.row_valid    = row_valid;
  assign bus.row_address  = row_address;
  assign bus.row_data_0   = row_data_0;
  assign bus.row_data_1   = row_data_1;
  assign bus.length_error = length_error;
  assign bus.overrun      = overrun;

endmodule
